serial_receiver_16: RTL

// UART receiver for the HC-05 TXD line (FPGA rxd side); inverse of serial_transmitter_16.
// - Deserializes 8N1 bytes LSB-first, packs byte pairs into 16-bit words (first byte -> [15:8]).
// - Presents each word with a one-cycle strobe for ATRFIFO wr_en.
// - Flags the "\r\n" AT-response terminator so the top FSM can leave Receive_AT_Response.

---
 rtl/serial_receiver_16.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/serial_receiver_16.sv
// 8N1 UART receiver: deserializes bytes LSB-first and packs byte pairs into 16-bit words.
// Flags the CR-LF terminator with at_end and flushes a lone LF as {8'h0A,8'h00}.
module serial_receiver_16 #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic        line_in,
  input  logic        fifo_full,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        at_end,
  output logic        frame_error,
  output logic        overflow,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            rx_meta, rx_s;
  logic            accept, ferr;
  logic            byte_phase, prev_cr;
  logic [7:0]      hi_reg;
  logic            term;

  // line_in is asynchronous; only rx_s is ever sampled
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= line_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    accept    = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: if (cnt == HALF) begin
        cnt_nxt   = '0;
        bit_nxt   = '0;
        state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == FULL) begin
        cnt_nxt            = '0;
        shift_nxt[bit_idx] = rx_s;
        if (bit_idx == 3'd7) state_nxt = STOP;
        else                 bit_nxt   = bit_idx + 3'd1;
      end
      STOP: if (cnt == FULL) begin
        cnt_nxt = '0;
        if (rx_s) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr      = 1'b1;
          state_nxt = RECOVER;
        end
      end
      RECOVER: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      accept    = 1'b0;
      ferr      = 1'b0;
    end
  end

  // shift holds the complete byte while in STOP
  assign term = prev_cr && (shift == 8'h0A);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      at_end      <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      byte_phase  <= 1'b0;
      prev_cr     <= 1'b0;
      hi_reg      <= '0;
    end else begin
      data_valid  <= 1'b0;
      at_end      <= 1'b0;
      frame_error <= ferr;
      overflow    <= overflow | (data_valid & fifo_full);
      if (!enable) begin
        byte_phase <= 1'b0;
        prev_cr    <= 1'b0;
      end else if (accept) begin
        prev_cr <= (shift == 8'h0D);
        if (byte_phase) begin
          data_out   <= {hi_reg, shift};
          data_valid <= 1'b1;
          at_end     <= term;
          byte_phase <= 1'b0;
        end else if (term) begin
          data_out   <= {8'h0A, 8'h00};
          data_valid <= 1'b1;
          at_end     <= 1'b1;
        end else begin
          hi_reg     <= shift;
          byte_phase <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
